// File: rtl/fir_pkg.sv
// Shared definitions for the FM audio decimating FIR and the downstream IIR stage.
package fir_pkg;

  localparam int unsigned FIR_DATA_WIDTH = 32;
  localparam int unsigned FIR_Q_BITS     = 10;
  localparam int unsigned FIR_NUM_TAPS   = 32;
  localparam int unsigned FIR_DECIM      = 8;
  localparam int unsigned COEF_WIDTH     = 32;
  localparam int unsigned PROD_WIDTH     = 2 * FIR_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  // Symmetric low-pass taps in Q10. Every magnitude is below 1.0 (1024).
  localparam logic signed [COEF_WIDTH-1:0] AUDIO_LPR_COEFFS [FIR_NUM_TAPS] = '{
    -32'sd2,   -32'sd4,   -32'sd6,   -32'sd5,   32'sd0,    32'sd10,   32'sd25,   32'sd45,
     32'sd70,   32'sd98,   32'sd126,  32'sd150,  32'sd168,  32'sd180,  32'sd186,  32'sd190,
     32'sd190,  32'sd186,  32'sd180,  32'sd168,  32'sd150,  32'sd126,  32'sd98,   32'sd70,
     32'sd45,   32'sd25,   32'sd10,   32'sd0,   -32'sd5,   -32'sd6,   -32'sd4,   -32'sd2
  };

  // Signed divide by 2^q_bits rounding toward zero: negative values are biased
  // up by (2^q_bits - 1) before the arithmetic shift so they do not round down.
  function automatic logic signed [PROD_WIDTH-1:0] dequantize(
    input logic signed [PROD_WIDTH-1:0] prod,
    input int unsigned                  q_bits
  );
    logic signed [PROD_WIDTH-1:0] bias;
    bias = prod[PROD_WIDTH-1] ? ((64'sd1 <<< q_bits) - 64'sd1) : '0;
    return (prod + bias) >>> q_bits;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply-accumulate: one dequantized sample*coefficient term per enabled cycle.
module fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int unsigned Q_BITS     = FIR_Q_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_sample,
  input  logic signed [COEF_WIDTH-1:0] i_coeff,
  output logic signed [DATA_WIDTH-1:0] o_acc
);

  logic        [PROD_WIDTH-1:0] w_sample_x;
  logic        [PROD_WIDTH-1:0] w_coeff_x;
  logic signed [PROD_WIDTH-1:0] w_prod;
  logic signed [DATA_WIDTH-1:0] w_term;
  logic signed [DATA_WIDTH-1:0] r_acc;

  // Full-width signed product, dequantized per term before accumulation.
  always_comb begin
    w_sample_x = {{(PROD_WIDTH-DATA_WIDTH){i_sample[DATA_WIDTH-1]}}, i_sample};
    w_coeff_x  = {{(PROD_WIDTH-COEF_WIDTH){i_coeff[COEF_WIDTH-1]}}, i_coeff};
    w_prod     = $signed(w_sample_x) * $signed(w_coeff_x);
    w_term     = DATA_WIDTH'(dequantize(w_prod, Q_BITS));
  end

  // Accumulator wraps at DATA_WIDTH; clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_term;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fir_decim.sv
// Decimating low-pass FIR: circular sample buffer, one MAC per clock, one output per DECIM inputs.
module fir_decim
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int unsigned NUM_TAPS   = FIR_NUM_TAPS,
  parameter int unsigned DECIM      = FIR_DECIM,
  parameter int unsigned Q_BITS     = FIR_Q_BITS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  input  logic                         dout_ready
);

  localparam int unsigned PTR_W = $clog2(NUM_TAPS);
  localparam int unsigned PH_W  = $clog2(DECIM);

  fir_state_e                   r_state;
  logic signed [DATA_WIDTH-1:0] r_buf [NUM_TAPS];
  logic        [PTR_W-1:0]      r_wr_ptr;
  logic        [PTR_W-1:0]      r_rd_ptr;
  logic        [PTR_W-1:0]      r_tap;
  logic        [PH_W-1:0]       r_phase;
  logic                         r_din_ready;
  logic signed [DATA_WIDTH-1:0] r_dout;
  logic                         r_dout_valid;

  logic                         w_accept;
  logic                         w_group_end;
  logic                         w_mac_en;
  logic        [PTR_W-1:0]      w_wr_ptr_nxt;
  logic signed [DATA_WIDTH-1:0] w_acc;

  // Handshake qualifiers and pointer wrap.
  always_comb begin
    w_accept     = (r_state == IDLE) && r_din_ready && din_valid;
    w_group_end  = w_accept && (r_phase == PH_W'(DECIM - 1));
    w_mac_en     = (r_state == MAC);
    w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(NUM_TAPS - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  end

  // Circular sample buffer; cleared on reset so a fresh stream sees zero history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= din;
    end
  end

  // Control FSM: collect DECIM samples, run NUM_TAPS MAC cycles, present one output.
  // The read pointer starts at the newest sample and walks backwards through history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tap        <= '0;
      r_phase      <= '0;
      r_din_ready  <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_din_ready <= 1'b1;
          if (w_accept) begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_phase  <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + PH_W'(1);
            if (w_group_end) begin
              r_state     <= MAC;
              r_tap       <= '0;
              r_rd_ptr    <= r_wr_ptr;
              r_din_ready <= 1'b0;
            end
          end
        end
        MAC: begin
          r_tap    <= r_tap + PTR_W'(1);
          r_rd_ptr <= (r_rd_ptr == '0) ? PTR_W'(NUM_TAPS - 1) : r_rd_ptr - PTR_W'(1);
          if (r_tap == PTR_W'(NUM_TAPS - 1)) begin
            r_state <= OUT;
          end
        end
        OUT: begin
          if (!r_dout_valid) begin
            r_dout       <= w_acc;
            r_dout_valid <= 1'b1;
          end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
            r_state      <= IDLE;
            r_din_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  fir_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q_BITS     (Q_BITS)
  ) u_mac (
    .clk      (clock),
    .rst_n    (reset),
    .i_clear  (w_group_end),
    .i_en     (w_mac_en),
    .i_sample (r_buf[r_rd_ptr]),
    .i_coeff  (AUDIO_LPR_COEFFS[r_tap]),
    .o_acc    (w_acc)
  );

  assign din_ready  = r_din_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_fir_decim.sv
// Directed and golden-model checks for the decimating FIR.
module tb_fir_decim;

  localparam int TH [32] = '{
    -2, -4, -6, -5, 0, 10, 25, 45, 70, 98, 126, 150, 168, 180, 186, 190,
    190, 186, 180, 168, 150, 126, 98, 70, 45, 25, 10, 0, -5, -6, -4, -2
  };

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic signed [31:0] din = '0;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic signed [31:0] dout;
  logic               dout_valid;
  logic               dout_ready = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic signed [31:0] mx [32];
  int                 mw = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  fir_decim #(
    .DATA_WIDTH (32),
    .NUM_TAPS   (32),
    .DECIM      (8),
    .Q_BITS     (10)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mx[i] = '0;
    mw = 0;
  endtask

  task automatic model_push(input logic signed [31:0] v);
    mx[mw] = v;
    mw = (mw + 1) % 32;
  endtask

  function automatic logic signed [31:0] model_out();
    logic [31:0] acc;
    longint      p;
    longint      q;
    int          idx;
    acc = '0;
    for (int k = 0; k < 32; k++) begin
      idx = (mw - 1 - k + 64) % 32;
      p   = longint'(mx[idx]) * longint'(TH[k]);
      q   = p / 1024;
      acc = acc + q[31:0];
    end
    return acc;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b0;
    din_valid  = 1'b0;
    din        = '0;
    dout_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    model_clear();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic signed [31:0] v, output int acc_edge);
    int budget;
    din       = v;
    din_valid = 1'b1;
    budget    = 0;
    acc_edge  = -1;
    while (!din_ready && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (!din_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: din_ready=%0b required 1", din_ready);
      din_valid = 1'b0;
    end else begin
      @(posedge clock);
      @(negedge clock);
      acc_edge  = cyc;
      din_valid = 1'b0;
    end
  endtask

  task automatic get_out(input string name, input logic signed [31:0] exp_v,
                         input int acc_edge, input bit chk_lat);
    int budget;
    budget = 0;
    while (!dout_valid && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    n_vec++;
    if (!dout_valid) begin
      n_err++;
      $display("FAIL %s: dout_valid timeout, got 0 required 1", name);
    end else if (dout !== exp_v) begin
      n_err++;
      $display("FAIL %s: dout=%0d required %0d", name, dout, exp_v);
    end
    if (chk_lat && dout_valid) begin
      n_vec++;
      if ((cyc - acc_edge) !== 33) begin
        n_err++;
        $display("FAIL %s_latency: edges=%0d required 33", name, cyc - acc_edge);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock);
    n_vec += 3;
    if (din_ready !== 1'b0) begin n_err++; $display("FAIL reset_din_ready: got %0b required 0", din_ready); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid: got %0b required 0", dout_valid); end
    if (dout !== 32'sd0) begin n_err++; $display("FAIL reset_dout: got %0d required 0", dout); end
    reset = 1'b1;
    @(negedge clock);
    n_vec++;
    if (din_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_din_ready: got %0b required 1", din_ready); end
    model_clear();
  endtask

  task automatic run_groups(input string name, input logic signed [31:0] first,
                            input logic signed [31:0] rest, input int groups,
                            input logic signed [31:0] exp_tab [6]);
    int e;
    for (int g = 0; g < groups; g++) begin
      for (int j = 0; j < 8; j++) begin
        push((g == 0 && j == 0) ? first : rest, e);
      end
      get_out(name, exp_tab[g], e, 1'b1);
    end
  endtask

  task automatic test_impulse();
    logic signed [31:0] tab [6];
    tab = '{32'sd45, 32'sd190, 32'sd70, -32'sd2, 32'sd0, 32'sd0};
    do_reset();
    run_groups("impulse", 32'sd1024, 32'sd0, 6, tab);
  endtask

  task automatic test_neg_impulse();
    logic signed [31:0] tab [6];
    tab = '{-32'sd45, -32'sd190, -32'sd70, 32'sd2, 32'sd0, 32'sd0};
    do_reset();
    run_groups("neg_impulse", -32'sd1024, 32'sd0, 5, tab);
  endtask

  task automatic test_dc();
    logic signed [31:0] tab [6];
    tab = '{32'sd63, 32'sd1231, 32'sd2399, 32'sd2462, 32'sd2462, 32'sd2462};
    do_reset();
    run_groups("dc", 32'sd1024, 32'sd1024, 6, tab);
  endtask

  task automatic test_small();
    logic signed [31:0] tab [6];
    tab = '{32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    do_reset();
    run_groups("small_pos", 32'sd1, 32'sd1, 5, tab);
    do_reset();
    run_groups("small_neg", -32'sd1, -32'sd1, 5, tab);
  endtask

  task automatic test_back_pressure();
    int                 e;
    logic signed [31:0] held;
    logic signed [31:0] v;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = 32'(i * 3001 - 9000);
      push(v, e);
      model_push(v);
    end
    dout_ready = 1'b0;
    held = model_out();
    get_out("bp_first", held, e, 1'b1);
    din       = 32'sd777;
    din_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      n_vec += 3;
      if (dout !== held) begin n_err++; $display("FAIL bp_hold_dout: got %0d required %0d", dout, held); end
      if (dout_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %0b required 1", dout_valid); end
      if (din_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_din_ready: got %0b required 0", din_ready); end
    end
    dout_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL bp_single_transfer: dout_valid=%0b required 0", dout_valid); end
    push(32'sd777, e);
    model_push(32'sd777);
    for (int i = 0; i < 7; i++) begin
      v = 32'(-(i * 12345) + 4321);
      push(v, e);
      model_push(v);
    end
    get_out("bp_next", model_out(), e, 1'b1);
  endtask

  task automatic test_random();
    int                 e;
    int                 gap;
    logic signed [31:0] v;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      gap = int'($urandom_range(0, 3));
      din_valid = 1'b0;
      repeat (gap) @(negedge clock);
      v = $urandom;
      push(v, e);
      model_push(v);
      if ((i % 8) == 7) get_out("random", model_out(), e, 1'b1);
    end
  endtask

  task automatic test_reset_mid_mac();
    int                 e;
    logic signed [31:0] tab [6];
    tab = '{32'sd45, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
    for (int i = 0; i < 7; i++) push(32'sd5000, e);
    push(32'sd2048, e);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    n_vec += 3;
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %0b required 0", dout_valid); end
    if (dout !== 32'sd0) begin n_err++; $display("FAIL midreset_dout: got %0d required 0", dout); end
    if (din_ready !== 1'b0) begin n_err++; $display("FAIL midreset_din_ready: got %0b required 0", din_ready); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_clear();
    @(negedge clock);
    n_vec += 2;
    if (din_ready !== 1'b1) begin n_err++; $display("FAIL midreset_release_ready: got %0b required 1", din_ready); end
    if (dout_valid !== 1'b0) begin n_err++; $display("FAIL midreset_release_valid: got %0b required 0", dout_valid); end
    run_groups("midreset_impulse", 32'sd1024, 32'sd0, 1, tab);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_neg_impulse();
    test_dc();
    test_small();
    test_back_pressure();
    test_random();
    test_reset_mid_mac();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
